// File: rtl/score4_pkg.sv
// Shared types and board constants for the Score 4 game controller.
package score4_pkg;
    localparam int COLS      = 7;
    localparam int ROWS      = 6;
    localparam int WIN_LEN   = 4;
    localparam int MAX_MOVES = 42;
    localparam logic [6:0] RESET_PLAY = 7'b0001000;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WON   = 2'd2,
        DRAWN = 2'd3
    } state_t;

    function automatic logic [1:0] turn_cell(input logic turn);
        return turn ? P1 : P0;
    endfunction
endpackage

// File: rtl/score4_run_counter.sv
// Combinational run-length counter: same-colour cells through an origin along one direction.
module score4_run_counter
    import score4_pkg::*;
(
    input  logic [COLS-1:0][ROWS-1:0][1:0] i_panel,
    input  logic [2:0]                     i_col,
    input  logic [2:0]                     i_row,
    input  logic [1:0]                     i_dir,
    input  logic [1:0]                     i_colour,
    output logic [2:0]                     o_run
);
    int         w_dc, w_dr;
    int         w_fc, w_fr, w_bc, w_br;
    logic       w_fgo, w_bgo;
    logic [2:0] w_fwd, w_bck;

    // dir 0..3: horizontal, vertical, down-right, up-right (row index grows downward)
    always_comb begin
        w_dc = 1;
        w_dr = 0;
        case (i_dir)
            2'd0:    begin w_dc = 1; w_dr = 0;  end
            2'd1:    begin w_dc = 0; w_dr = 1;  end
            2'd2:    begin w_dc = 1; w_dr = 1;  end
            default: begin w_dc = 1; w_dr = -1; end
        endcase
    end

    always_comb begin
        w_fwd = '0;
        w_bck = '0;
        w_fgo = 1'b1;
        w_bgo = 1'b1;
        w_fc  = 0;
        w_fr  = 0;
        w_bc  = 0;
        w_br  = 0;
        for (int k = 1; k < WIN_LEN; k++) begin
            w_fc = int'(i_col) + k * w_dc;
            w_fr = int'(i_row) + k * w_dr;
            w_bc = int'(i_col) - k * w_dc;
            w_br = int'(i_row) - k * w_dr;
            if (w_fgo && w_fc >= 0 && w_fc < COLS && w_fr >= 0 && w_fr < ROWS &&
                i_panel[w_fc[2:0]][w_fr[2:0]] == i_colour)
                w_fwd = w_fwd + 3'd1;
            else
                w_fgo = 1'b0;
            if (w_bgo && w_bc >= 0 && w_bc < COLS && w_br >= 0 && w_br < ROWS &&
                i_panel[w_bc[2:0]][w_br[2:0]] == i_colour)
                w_bck = w_bck + 3'd1;
            else
                w_bgo = 1'b0;
        end
    end

    assign o_run = 3'd1 + w_fwd + w_bck;
endmodule

// File: rtl/score4_game_ctrl.sv
// Score 4 game sequencer: board, selection, turn, and a one-direction-per-cycle win check.
module score4_game_ctrl
    import score4_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_key_left,
    input  logic                           i_key_right,
    input  logic                           i_key_put,
    input  logic                           i_new_game,
    output logic [COLS-1:0][ROWS-1:0][1:0] o_panel,
    output logic [COLS-1:0]                o_play,
    output logic                           o_turn,
    output logic                           o_win,
    output logic                           o_draw,
    output logic                           o_busy
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CHECK = CHECK;
    localparam logic [1:0] S_WON   = WON;
    localparam logic [1:0] S_DRAWN = DRAWN;

    logic [COLS-1:0][ROWS-1:0][1:0] r_panel, w_panel_nxt;
    logic [COLS-1:0]                r_play,  w_play_nxt;
    logic                           r_turn,  w_turn_nxt;
    logic                           r_win,   w_win_nxt;
    logic                           r_draw,  w_draw_nxt;
    logic [1:0]                     r_state, w_state_nxt;
    logic [1:0]                     r_dir,   w_dir_nxt;
    logic [5:0]                     r_moves, w_moves_nxt;
    logic [2:0]                     r_org_col, w_org_col_nxt;
    logic [2:0]                     r_org_row, w_org_row_nxt;

    logic [2:0] w_sel_col;
    logic [2:0] w_tgt_row;
    logic       w_col_full;
    logic [2:0] w_run;
    logic       w_run_win;

    always_comb begin
        w_sel_col = '0;
        for (int c = 0; c < COLS; c++)
            if (r_play[c]) w_sel_col = 3'(c);
    end

    // Lowest empty cell in the selected column (largest row index).
    always_comb begin
        w_tgt_row = '0;
        for (int r = 0; r < ROWS; r++)
            if (r_panel[w_sel_col][r] == EMPTY) w_tgt_row = 3'(r);
    end

    assign w_col_full = (r_panel[w_sel_col][0] != EMPTY);

    score4_run_counter u_run (
        .i_panel  (r_panel),
        .i_col    (r_org_col),
        .i_row    (r_org_row),
        .i_dir    (r_dir),
        .i_colour (turn_cell(r_turn)),
        .o_run    (w_run)
    );

    assign w_run_win = (w_run >= 3'(WIN_LEN));

    always_comb begin
        w_panel_nxt   = r_panel;
        w_play_nxt    = r_play;
        w_turn_nxt    = r_turn;
        w_win_nxt     = r_win;
        w_draw_nxt    = r_draw;
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_moves_nxt   = r_moves;
        w_org_col_nxt = r_org_col;
        w_org_row_nxt = r_org_row;
        if (i_new_game) begin
            w_panel_nxt   = '0;
            w_play_nxt    = RESET_PLAY;
            w_turn_nxt    = 1'b0;
            w_win_nxt     = 1'b0;
            w_draw_nxt    = 1'b0;
            w_state_nxt   = S_IDLE;
            w_dir_nxt     = '0;
            w_moves_nxt   = '0;
            w_org_col_nxt = '0;
            w_org_row_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_key_put) begin
                        if (!w_col_full) begin
                            w_panel_nxt[w_sel_col][w_tgt_row] = turn_cell(r_turn);
                            w_moves_nxt   = r_moves + 6'd1;
                            w_state_nxt   = S_CHECK;
                            w_dir_nxt     = '0;
                            w_org_col_nxt = w_sel_col;
                            w_org_row_nxt = w_tgt_row;
                        end
                    end else if (i_key_left && !i_key_right) begin
                        w_play_nxt = {r_play[0], r_play[COLS-1:1]};
                    end else if (i_key_right && !i_key_left) begin
                        w_play_nxt = {r_play[COLS-2:0], r_play[COLS-1]};
                    end
                end
                S_CHECK: begin
                    if (w_run_win) begin
                        w_win_nxt   = 1'b1;
                        w_state_nxt = S_WON;
                    end else if (r_dir == 2'd3) begin
                        if (r_moves == 6'(MAX_MOVES)) begin
                            w_draw_nxt  = 1'b1;
                            w_state_nxt = S_DRAWN;
                        end else begin
                            w_turn_nxt  = ~r_turn;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_dir_nxt = r_dir + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_panel   <= '0;
            r_play    <= RESET_PLAY;
            r_turn    <= 1'b0;
            r_win     <= 1'b0;
            r_draw    <= 1'b0;
            r_state   <= S_IDLE;
            r_dir     <= '0;
            r_moves   <= '0;
            r_org_col <= '0;
            r_org_row <= '0;
        end else begin
            r_panel   <= w_panel_nxt;
            r_play    <= w_play_nxt;
            r_turn    <= w_turn_nxt;
            r_win     <= w_win_nxt;
            r_draw    <= w_draw_nxt;
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_moves   <= w_moves_nxt;
            r_org_col <= w_org_col_nxt;
            r_org_row <= w_org_row_nxt;
        end
    end

    assign o_panel = r_panel;
    assign o_play  = r_play;
    assign o_turn  = r_turn;
    assign o_win   = r_win;
    assign o_draw  = r_draw;
    assign o_busy  = (r_state == S_CHECK);
endmodule
